// File: rtl/de1_pkg.sv
// Shared constants for the "dE1" message rotator.
// Character codes, rotation directions and the reset message builder.
package de1_pkg;

  localparam logic [1:0] CHAR_D     = 2'b00;
  localparam logic [1:0] CHAR_E     = 2'b01;
  localparam logic [1:0] CHAR_1     = 2'b10;
  localparam logic [1:0] CHAR_BLANK = 2'b11;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  localparam int MAX_DISP = 32;

  // "dE1" on the leftmost displays, blanks elsewhere.
  // Result is MAX_DISP wide; callers keep the low 2*n bits.
  function automatic logic [2*MAX_DISP-1:0] reset_msg(input int n);
    logic [2*MAX_DISP-1:0] m;
    m = '1;
    for (int i = 0; i < MAX_DISP; i++) begin
      if (i == n - 1)
        m[2*i +: 2] = CHAR_D;
      else if (i == n - 2)
        m[2*i +: 2] = CHAR_E;
      else if (i == n - 3)
        m[2*i +: 2] = CHAR_1;
    end
    return m;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing one advance tick per TICK_DIV enabled cycles.
// Count holds while disabled; clr restarts it from zero.
module tick_prescaler #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic resetn,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en & ~clr & (cnt == LAST);

  // Count 0..TICK_DIV-1 while enabled, wrap at the end.
  always_ff @(posedge clk) begin
    if (!resetn)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (en)
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
  end

endmodule

// File: rtl/de1_message_rotator.sv
// Rotates the "dE1" message across a bank of seven-segment decoders.
// Automatic (prescaled) or manual step-key rotation; load replaces it.
module de1_message_rotator
  import de1_pkg::*;
#(
  parameter int NUM_DISP = 4,
  parameter int TICK_DIV = 50_000_000
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        run,
  input  logic                        dir,
  input  logic                        step,
  input  logic                        load,
  input  logic [2*NUM_DISP-1:0]       load_data,
  output logic [2*NUM_DISP-1:0]       codes,
  output logic                        shifted,
  output logic [$clog2(NUM_DISP)-1:0] pos
);

  localparam int W  = 2 * NUM_DISP;
  localparam int PW = $clog2(NUM_DISP);

  localparam logic [2*MAX_DISP-1:0] RST_FULL =
    reset_msg(NUM_DISP);
  localparam logic [W-1:0] RST_MSG = RST_FULL[W-1:0];
  localparam logic [PW-1:0] PMAX = PW'(NUM_DISP - 1);

  logic          tick;
  logic          step_q;
  logic          adv;
  logic [W-1:0]  codes_nx;
  logic [PW-1:0] pos_nx;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_presc (
    .clk    (clk),
    .resetn (resetn),
    .en     (run),
    .clr    (load),
    .tick   (tick)
  );

  // Load wins: a coincident advance is dropped.
  assign adv = ~load & (tick | (step & ~step_q & ~run));

  // Next message and rotation count.
  always_comb begin
    codes_nx = codes;
    pos_nx   = pos;
    unique case (1'b1)
      load: begin
        codes_nx = load_data;
        pos_nx   = '0;
      end
      adv && (dir == DIR_LEFT): begin
        codes_nx = {codes[W-3:0], codes[W-1:W-2]};
        pos_nx   = (pos == PMAX) ? '0 : pos + 1'b1;
      end
      adv && (dir == DIR_RIGHT): begin
        codes_nx = {codes[1:0], codes[W-1:2]};
        pos_nx   = (pos == '0) ? PMAX : pos - 1'b1;
      end
      default: ;
    endcase
  end

  // Registered code bus, pos, shift pulse and step history.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      codes   <= RST_MSG;
      pos     <= '0;
      shifted <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      codes   <= codes_nx;
      pos     <= pos_nx;
      shifted <= adv;
      step_q  <= step;
    end
  end

endmodule

// File: tb/tb_de1_message_rotator.sv
// Directed bench for de1_message_rotator (NUM_DISP=4, TICK_DIV=4).
// Table rows plus hand-written reset sequences.
module tb_de1_message_rotator;

  logic       clk = 1'b0;
  logic       resetn;
  logic       run;
  logic       dir;
  logic       step;
  logic       load;
  logic [7:0] load_data;
  logic [7:0] codes;
  logic       shifted;
  logic [1:0] pos;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic       run;
    logic       dir;
    logic       step;
    logic       load;
    logic [7:0] ld;
    int         n;
    logic [7:0] e_codes;
    logic [1:0] e_pos;
    logic       e_sh;
  } vec_t;

  vec_t vecs[$];

  de1_message_rotator #(
    .NUM_DISP (4),
    .TICK_DIV (4)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .run       (run),
    .dir       (dir),
    .step      (step),
    .load      (load),
    .load_data (load_data),
    .codes     (codes),
    .shifted   (shifted),
    .pos       (pos)
  );

  always #5 clk = ~clk;

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [7:0] ec,
                       input logic [1:0] ep, input logic es);
    tests++;
    if (codes !== ec) begin
      fails++;
      $display("FAIL %s codes: got %h want %h", nm, codes, ec);
    end
    tests++;
    if (pos !== ep) begin
      fails++;
      $display("FAIL %s pos: got %0d want %0d", nm, pos, ep);
    end
    tests++;
    if (shifted !== es) begin
      fails++;
      $display("FAIL %s shifted: got %b want %b", nm, shifted, es);
    end
  endtask

  task automatic add(input logic r, input logic d, input logic s,
                     input logic l, input logic [7:0] ld, input int n,
                     input logic [7:0] ec, input logic [1:0] ep,
                     input logic es);
    vec_t v;
    v.run = r; v.dir = d; v.step = s; v.load = l; v.ld = ld;
    v.n = n; v.e_codes = ec; v.e_pos = ep; v.e_sh = es;
    vecs.push_back(v);
  endtask

  initial begin
    //  run dir stp ld  data  n  codes pos sh
    add(0, 0, 0, 0, 8'h00, 0, 8'h1B, 0, 0);
    add(1, 0, 0, 0, 8'h00, 3, 8'h1B, 0, 0);
    add(1, 0, 0, 0, 8'h00, 1, 8'h6C, 1, 1);
    add(1, 0, 0, 0, 8'h00, 1, 8'h6C, 1, 0);
    add(1, 0, 0, 0, 8'h00, 3, 8'hB1, 2, 1);
    add(1, 0, 0, 0, 8'h00, 4, 8'hC6, 3, 1);
    add(1, 0, 0, 0, 8'h00, 4, 8'h1B, 0, 1);
    add(1, 1, 0, 0, 8'h00, 4, 8'hC6, 3, 1);
    add(1, 1, 0, 0, 8'h00, 2, 8'hC6, 3, 0);
    add(1, 0, 0, 0, 8'h00, 2, 8'h1B, 0, 1);
    add(0, 0, 1, 0, 8'h00, 1, 8'h6C, 1, 1);
    add(0, 0, 1, 0, 8'h00, 4, 8'h6C, 1, 0);
    add(0, 0, 0, 0, 8'h00, 1, 8'h6C, 1, 0);
    add(1, 0, 1, 0, 8'h00, 1, 8'h6C, 1, 0);
    add(1, 0, 1, 0, 8'h00, 3, 8'hB1, 2, 1);
    add(1, 0, 0, 0, 8'h00, 2, 8'hB1, 2, 0);
    add(0, 0, 0, 0, 8'h00, 10, 8'hB1, 2, 0);
    add(1, 0, 0, 0, 8'h00, 1, 8'hB1, 2, 0);
    add(1, 0, 0, 0, 8'h00, 1, 8'hC6, 3, 1);
    add(1, 0, 0, 0, 8'h00, 3, 8'hC6, 3, 0);
    add(1, 0, 0, 1, 8'hFF, 1, 8'hFF, 0, 0);
    add(1, 0, 0, 0, 8'h00, 3, 8'hFF, 0, 0);
    add(1, 0, 0, 0, 8'h00, 1, 8'hFF, 1, 1);
    add(0, 0, 0, 1, 8'hE4, 1, 8'hE4, 0, 0);
    add(0, 0, 1, 0, 8'h00, 1, 8'h93, 1, 1);
    add(0, 1, 0, 0, 8'h00, 1, 8'h93, 1, 0);
    add(0, 1, 1, 0, 8'h00, 1, 8'hE4, 0, 1);
    add(0, 1, 0, 0, 8'h00, 1, 8'hE4, 0, 0);
    add(0, 1, 1, 1, 8'h1B, 1, 8'h1B, 0, 0);
    add(0, 1, 1, 0, 8'h00, 1, 8'h1B, 0, 0);
    add(0, 1, 0, 0, 8'h00, 1, 8'h1B, 0, 0);
    add(0, 1, 1, 0, 8'h00, 1, 8'hC6, 3, 1);

    resetn = 1'b0;
    run = 0; dir = 0; step = 0; load = 0; load_data = '0;
    edges(2);
    resetn = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      run       = vecs[i].run;
      dir       = vecs[i].dir;
      step      = vecs[i].step;
      load      = vecs[i].load;
      load_data = vecs[i].ld;
      edges(vecs[i].n);
      check($sformatf("row%0d", i), vecs[i].e_codes,
            vecs[i].e_pos, vecs[i].e_sh);
    end

    // Reset beats a coincident load.
    run = 0; dir = 0; step = 0;
    resetn = 1'b0; load = 1'b1; load_data = 8'hFF;
    edges(1);
    check("rst_over_load", 8'h1B, 0, 0);

    // Two rotations, then reset mid-count.
    resetn = 1'b1; load = 1'b0; load_data = '0; run = 1'b1;
    edges(8);
    check("pre_rst", 8'hB1, 2, 1);
    edges(2);
    check("mid_count", 8'hB1, 2, 0);
    resetn = 1'b0;
    edges(1);
    check("rst_mid", 8'h1B, 0, 0);
    resetn = 1'b1;
    edges(3);
    check("post_rst_hold", 8'h1B, 0, 0);
    edges(1);
    check("post_rst_step", 8'h6C, 1, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/de1_message_rotator.md
Name: dE1_message_rotator

Overview:
- Upstream producer of 2-bit character codes for a bank of seven_segment_decoder instances, one instance per HEX display.
- Holds the message "dE1" padded with blanks, one character per display.
- Rotates the message left or right at a prescaled rate, or one step per manual key press.
- Drives all decoders in parallel from a registered code bus.

Parameters:
- NUM_DISP, 4, number of displays/characters (≥3).
- TICK_DIV, 50_000_000, clock cycles per automatic rotation step (≥2).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- resetn  input  1  synchronous, active-low reset.
- run  input  1  1 = automatic rotation at TICK_DIV rate; 0 = paused.
- dir  input  1  0 = rotate left (toward higher display index); 1 = rotate right.
- step  input  1  manual advance request, synchronous debounced level; acts on its 0→1 edge only.
- load  input  1  1-cycle strobe: replace message with load_data.
- load_data  input  2*NUM_DISP  new message, same packing as codes.
- codes  output  2*NUM_DISP  codes[2i+1:2i] drives display i (display 0 rightmost).
- shifted  output  1  1-cycle pulse, high in the cycle codes shows a new rotation.
- pos  output  clog2(NUM_DISP)  net left-rotation count mod NUM_DISP.

Behaviour:
- Character codes: 00='d', 01='E', 10='1', 11=blank.
- All state updates occur on rising clk only.
- Reset (resetn=0 at an edge):
  - codes = 'd' on display NUM_DISP-1, 'E' on NUM_DISP-2, '1' on NUM_DISP-3, blank on all others. For NUM_DISP=4: 8'b00_01_10_11 = 0x1B.
  - pos=0, shifted=0, prescaler count=0, step edge-detect history=0.
  - Reset overrides all other inputs, including mid-count and during load.
- Prescaler:
  - Count runs 0..TICK_DIV-1 while run=1.
  - At TICK_DIV-1 it wraps to 0 and raises the internal advance for that cycle.
  - run=0 holds the count; it is not cleared.
- Manual step:
  - Internal advance when step=1 and the previous-cycle step=0, and run=0.
  - Step edges while run=1 are ignored. The history register still updates, so holding step through a run→0 transition does not advance.
- Rotate left, on the edge after advance: new display i = old display i-1; new display 0 = old display NUM_DISP-1; pos = pos+1 mod NUM_DISP.
- Rotate right: new display i = old display i+1; new display NUM_DISP-1 = old display 0; pos = pos-1 mod NUM_DISP (0 wraps to NUM_DISP-1).
- dir is sampled in the advance cycle. A change between steps takes effect at the next step, with no extra shift.
- shifted = 1 exactly in the cycle after each rotation edge, otherwise 0.
- Latency:
  - Automatic: codes change on the TICK_DIV-th rising edge with run=1 after prescaler count 0, then every TICK_DIV edges.
  - Manual: codes change 1 edge after the step edge is sampled.
- Load (priority over advance in the same cycle):
  - codes=load_data, pos=0, prescaler count=0, shifted=0.
  - A coincident advance is discarded.
- codes is always a direct register output with no combinational path from inputs. Decoders consume it unmodified.

Decomposition:
- Shared package dE1_pkg:
  - constants CHAR_D, CHAR_E, CHAR_1, CHAR_BLANK (2 bits each);
  - function returning the reset message for a given NUM_DISP;
  - DIR_LEFT=0, DIR_RIGHT=1.
- One sub-module, tick_prescaler (parameter TICK_DIV; ports clk, resetn, en, clr, tick). The top instantiates it with en=run and clr=load.
- Rotation, edge detection and pos live in the top module.

Test Plan (NUM_DISP=4, TICK_DIV=4):
- Reset, then run=1, dir=0 from edge 0 → codes=0x1B for 3 edges. On edge 4: codes=0x6C, shifted=1 for one cycle, pos=1. After 4 more steps: back to 0x1B, pos=0 (wrap).
- run=1, dir=1 from reset → first step codes=0xC6, pos=3. Toggle dir to 0 mid-count → next step gives 0x1B, pos=0.
- run=0; step 0→1 held high for 5 cycles → exactly one rotation (0x1B→0x6C) 1 edge later. Same step pulse with run=1 → no extra shift beyond prescaler steps.
- run=1; prescaler count=2, then run=0 for 10 cycles, then run=1 → rotation occurs 2 edges after re-enable (count held, not cleared).
- load=1 with load_data=0xFF in the same cycle as a prescaler tick → codes=0xFF, pos=0, shifted=0, no rotation. Next step occurs 4 edges later.
- Assert resetn=0 mid-count after two rotations → next edge: codes=0x1B, pos=0, shifted=0. The first step after release needs a full 4 edges.
